sha_io_timer_ctrl: RTL and testbench

//  Memory-mapped LED and GPIO timing controller for the SHA-1 accelerator board top level.

---
 rtl/sha_io_pkg.sv | 22 ++
 rtl/sha_io_tmr_ch.sv | 75 +++++++
 rtl/sha_io_timer_ctrl.sv | 120 ++++++++++++
 tb/tb_sha_io_timer_ctrl.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha_io_pkg.sv
// Shared definitions for the SHA board LED/GPIO timing controller:
// register map, command/status bit offsets and timer channel states.
package sha_io_pkg;

    localparam logic [2:0] ADDR_LED_VAL    = 3'd0;
    localparam logic [2:0] ADDR_LED_BLINK  = 3'd1;
    localparam logic [2:0] ADDR_BLINK_HALF = 3'd2;
    localparam logic [2:0] ADDR_GPIO_CMD   = 3'd3;
    localparam logic [2:0] ADDR_TIMEOUT    = 3'd4;
    localparam logic [2:0] ADDR_STATUS     = 3'd5;

    localparam int CMD_START_LSB = 0;
    localparam int CMD_STOP_LSB  = 16;
    localparam int STAT_RUN_LSB  = 0;
    localparam int STAT_EXP_LSB  = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ch_state_e;

endpackage

// File: rtl/sha_io_tmr_ch.sv
// One hardware countdown channel: run is high for exactly 'load' cycles after a
// start, and expire_pulse fires in the last counting cycle of a natural expiry.
module sha_io_tmr_ch
    import sha_io_pkg::*;
#(
    parameter int TMR_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic [TMR_W-1:0] load,
    output logic             run,
    output logic             expire_pulse
);

    ch_state_e        state, state_nxt;
    logic [TMR_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Stop has priority over start; a zero load expires immediately instead of running.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        expire_pulse = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    if (load == '0) begin
                        expire_pulse = 1'b1;
                    end else begin
                        state_nxt = RUN;
                        cnt_nxt   = load;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (start) begin
                    if (load == '0) begin
                        state_nxt    = IDLE;
                        cnt_nxt      = '0;
                        expire_pulse = 1'b1;
                    end else begin
                        cnt_nxt = load;
                    end
                end else if (cnt == TMR_W'(1)) begin
                    state_nxt    = IDLE;
                    cnt_nxt      = '0;
                    expire_pulse = 1'b1;
                end else begin
                    cnt_nxt = cnt - TMR_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign run = (state == RUN);

endmodule

// File: rtl/sha_io_timer_ctrl.sv
// Avalon-MM LED/GPIO timing controller: register file, blink generator,
// sticky expiry flags and NUM_GPIO countdown channels driving marker pins.
module sha_io_timer_ctrl
    import sha_io_pkg::*;
#(
    parameter int NUM_LEDS = 8,
    parameter int NUM_GPIO = 2,
    parameter int TMR_W    = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [2:0]          avs_address,
    input  logic                avs_write,
    input  logic [31:0]         avs_writedata,
    input  logic                avs_read,
    output logic [31:0]         avs_readdata,
    output logic [NUM_LEDS-1:0] leds,
    output logic [NUM_GPIO-1:0] gpio
);

    logic [NUM_LEDS-1:0] led_val;
    logic [NUM_LEDS-1:0] led_blink;
    logic [TMR_W-1:0]    blink_half;
    logic [TMR_W-1:0]    blink_cnt;
    logic                blink_phase;
    logic [TMR_W-1:0]    timeout;
    logic [NUM_GPIO-1:0] expired;

    logic [NUM_GPIO-1:0] ch_start, ch_stop, ch_run, ch_expire, w1c;
    logic                wr_led_val, wr_led_blink, wr_blink_half, wr_cmd, wr_timeout, wr_status;
    logic [31:0]         rd_data;

    assign wr_led_val    = avs_write && (avs_address == ADDR_LED_VAL);
    assign wr_led_blink  = avs_write && (avs_address == ADDR_LED_BLINK);
    assign wr_blink_half = avs_write && (avs_address == ADDR_BLINK_HALF);
    assign wr_cmd        = avs_write && (avs_address == ADDR_GPIO_CMD);
    assign wr_timeout    = avs_write && (avs_address == ADDR_TIMEOUT);
    assign wr_status     = avs_write && (avs_address == ADDR_STATUS);

    assign ch_start = wr_cmd    ? avs_writedata[CMD_START_LSB +: NUM_GPIO] : '0;
    assign ch_stop  = wr_cmd    ? avs_writedata[CMD_STOP_LSB  +: NUM_GPIO] : '0;
    assign w1c      = wr_status ? avs_writedata[STAT_EXP_LSB  +: NUM_GPIO] : '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            led_val    <= '0;
            led_blink  <= '0;
            blink_half <= '0;
            timeout    <= '0;
            expired    <= '0;
        end else begin
            if (wr_led_val)    led_val    <= avs_writedata[NUM_LEDS-1:0];
            if (wr_led_blink)  led_blink  <= avs_writedata[NUM_LEDS-1:0];
            if (wr_blink_half) blink_half <= avs_writedata[TMR_W-1:0];
            if (wr_timeout)    timeout    <= avs_writedata[TMR_W-1:0];
            // A fresh expiry beats a simultaneous write-1-to-clear.
            expired <= ch_expire | (expired & ~w1c);
        end
    end

    // Blink generator restarts from phase 0 whenever the half-period is rewritten.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            leds        <= '0;
        end else begin
            if (wr_blink_half || (blink_half == '0)) begin
                blink_cnt   <= '0;
                blink_phase <= 1'b0;
            end else if (blink_cnt >= blink_half - TMR_W'(1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + TMR_W'(1);
            end
            leds <= led_val & (~led_blink | {NUM_LEDS{blink_phase}});
        end
    end

    for (genvar g = 0; g < NUM_GPIO; g++) begin : g_ch
        sha_io_tmr_ch #(
            .TMR_W(TMR_W)
        ) u_ch (
            .clk         (clk),
            .reset_n     (reset_n),
            .start       (ch_start[g]),
            .stop        (ch_stop[g]),
            .load        (timeout),
            .run         (ch_run[g]),
            .expire_pulse(ch_expire[g])
        );
    end

    assign gpio = ch_run;

    always_comb begin
        rd_data = '0;
        case (avs_address)
            ADDR_LED_VAL:    rd_data[NUM_LEDS-1:0] = led_val;
            ADDR_LED_BLINK:  rd_data[NUM_LEDS-1:0] = led_blink;
            ADDR_BLINK_HALF: rd_data[TMR_W-1:0]    = blink_half;
            ADDR_TIMEOUT:    rd_data[TMR_W-1:0]    = timeout;
            ADDR_STATUS: begin
                rd_data[STAT_RUN_LSB +: NUM_GPIO] = ch_run;
                rd_data[STAT_EXP_LSB +: NUM_GPIO] = expired;
            end
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            avs_readdata <= '0;
        end else if (avs_read) begin
            avs_readdata <= rd_data;
        end
    end

endmodule

// File: tb/tb_sha_io_timer_ctrl.sv
// Self-checking bench for sha_io_timer_ctrl: randomized register/timer/blink
// scenarios compared against arithmetic expectations derived from the register rules.
module tb_sha_io_timer_ctrl;

    localparam int NUM_LEDS = 8;
    localparam int NUM_GPIO = 2;
    localparam int TMR_W    = 32;

    localparam logic [2:0] A_LED_VAL = 3'd0, A_LED_BLINK = 3'd1, A_BLINK_HALF = 3'd2;
    localparam logic [2:0] A_GPIO_CMD = 3'd3, A_TIMEOUT = 3'd4, A_STATUS = 3'd5;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [2:0]          avs_address = '0;
    logic                avs_write = 1'b0;
    logic [31:0]         avs_writedata = '0;
    logic                avs_read = 1'b0;
    logic [31:0]         avs_readdata;
    logic [NUM_LEDS-1:0] leds;
    logic [NUM_GPIO-1:0] gpio;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int wr_cyc   = 0;
    int hi_cnt [NUM_GPIO] = '{default: 0};

    sha_io_timer_ctrl #(
        .NUM_LEDS(NUM_LEDS),
        .NUM_GPIO(NUM_GPIO),
        .TMR_W   (TMR_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .avs_address  (avs_address),
        .avs_write    (avs_write),
        .avs_writedata(avs_writedata),
        .avs_read     (avs_read),
        .avs_readdata (avs_readdata),
        .leds         (leds),
        .gpio         (gpio)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Running tally of high samples per marker pin; tests look at deltas.
    always @(negedge clk) begin
        for (int i = 0; i < NUM_GPIO; i++)
            if (gpio[i]) hi_cnt[i] <= hi_cnt[i] + 1;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        @(posedge clk);
        #1;
        wr_cyc    = cyc;
        avs_write = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        avs_address = a;
        avs_read    = 1'b1;
        @(posedge clk);
        #1;
        avs_read = 1'b0;
        d        = avs_readdata;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        reset_n = 1'b0;
        idle(3);
        reset_n = 1'b1;
        idle(1);
        bus_write(A_LED_VAL, 32'hA5);
        bus_write(A_LED_BLINK, 32'h0F);
        bus_write(A_BLINK_HALF, 32'd3);
        bus_write(A_TIMEOUT, 32'd500);
        bus_write(A_GPIO_CMD, 32'h3);
        idle(5);
        bus_read(A_TIMEOUT, rd);
        n_checks++;
        if (rd !== 32'd500) begin
            n_fail++;
            $display("FAIL pre_reset_readback: got %h want %h", rd, 32'd500);
        end
        n_checks++;
        if (gpio !== 2'b11) begin
            n_fail++;
            $display("FAIL pre_reset_gpio: got %b want 11", gpio);
        end
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (leds !== '0 || gpio !== '0 || avs_readdata !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got leds=%h gpio=%b rd=%h want all 0", leds, gpio, avs_readdata);
        end
        @(posedge clk);
        #1;
        idle(10);
        n_checks++;
        if (gpio !== '0) begin
            n_fail++;
            $display("FAIL reset_gpio_stays_low: got %b want 0", gpio);
        end
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), rd);
            n_checks++;
            if (rd !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_readback_addr%0d: got %h want 0", a, rd);
            end
        end
    endtask

    task automatic test_timeout();
        logic [31:0] rd;
        int t, ch, exp_hi;
        int base [NUM_GPIO];
        for (int it = 0; it < 6; it++) begin
            t  = (it == 0) ? 10 : int'($urandom_range(1, 40));
            ch = (it == 0) ? 0 : int'($urandom_range(0, NUM_GPIO - 1));
            bus_write(A_TIMEOUT, 32'(t));
            for (int i = 0; i < NUM_GPIO; i++) base[i] = hi_cnt[i];
            bus_write(A_GPIO_CMD, 32'(1) << ch);
            bus_write(A_TIMEOUT, 32'(t + 7));
            idle(t + 4);
            for (int i = 0; i < NUM_GPIO; i++) begin
                exp_hi = (i == ch) ? t : 0;
                n_checks++;
                if (hi_cnt[i] - base[i] !== exp_hi) begin
                    n_fail++;
                    $display("FAIL timeout_high_cycles ch%0d T=%0d: got %0d want %0d", i, t, hi_cnt[i] - base[i], exp_hi);
                end
            end
            bus_read(A_STATUS, rd);
            n_checks++;
            if (rd !== (32'(1) << (16 + ch))) begin
                n_fail++;
                $display("FAIL timeout_status ch%0d: got %h want %h", ch, rd, 32'(1) << (16 + ch));
            end
            bus_write(A_STATUS, 32'hFFFF_0000);
            bus_read(A_STATUS, rd);
            n_checks++;
            if (rd !== 32'h0) begin
                n_fail++;
                $display("FAIL status_w1c: got %h want 0", rd);
            end
        end
    endtask

    task automatic test_retrigger_stop();
        logic [31:0] rd;
        int t, m, ch, t0, t1, b;
        for (int it = 0; it < 4; it++) begin
            ch = (it == 0) ? 0 : int'($urandom_range(0, NUM_GPIO - 1));
            t  = (it == 0) ? 100 : int'($urandom_range(20, 80));
            m  = (it == 0) ? 50 : int'($urandom_range(2, t - 1));
            bus_write(A_TIMEOUT, 32'(t));
            b = hi_cnt[ch];
            bus_write(A_GPIO_CMD, 32'(1) << ch);
            t0 = wr_cyc;
            idle(m - 1);
            bus_write(A_GPIO_CMD, 32'(1) << ch);
            t1 = wr_cyc;
            idle(t + 4);
            n_checks++;
            if (hi_cnt[ch] - b !== (t1 - t0) + t) begin
                n_fail++;
                $display("FAIL retrigger_high_cycles ch%0d: got %0d want %0d", ch, hi_cnt[ch] - b, (t1 - t0) + t);
            end
            bus_read(A_STATUS, rd);
            n_checks++;
            if (rd !== (32'(1) << (16 + ch))) begin
                n_fail++;
                $display("FAIL retrigger_status ch%0d: got %h want %h", ch, rd, 32'(1) << (16 + ch));
            end
            bus_write(A_STATUS, 32'hFFFF_0000);

            b = hi_cnt[ch];
            bus_write(A_GPIO_CMD, 32'(1) << ch);
            t0 = wr_cyc;
            bus_read(A_STATUS, rd);
            n_checks++;
            if (rd !== (32'(1) << ch)) begin
                n_fail++;
                $display("FAIL running_status ch%0d: got %h want %h", ch, rd, 32'(1) << ch);
            end
            idle(m - 2);
            bus_write(A_GPIO_CMD, 32'(1) << (16 + ch));
            t1 = wr_cyc;
            idle(5);
            n_checks++;
            if (hi_cnt[ch] - b !== t1 - t0) begin
                n_fail++;
                $display("FAIL stop_high_cycles ch%0d: got %0d want %0d", ch, hi_cnt[ch] - b, t1 - t0);
            end
            bus_read(A_STATUS, rd);
            n_checks++;
            if (rd !== 32'h0) begin
                n_fail++;
                $display("FAIL stop_status ch%0d: got %h want 0", ch, rd);
            end
        end
    endtask

    task automatic test_edge_cases();
        logic [31:0] rd;
        int b, t;
        bus_write(A_TIMEOUT, 32'd10);
        b = hi_cnt[0];
        bus_write(A_GPIO_CMD, 32'h0001_0001);
        idle(12);
        bus_read(A_STATUS, rd);
        n_checks++;
        if (hi_cnt[0] - b !== 0 || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL start_stop_same_write: got high=%0d status=%h want 0 and 0", hi_cnt[0] - b, rd);
        end
        bus_write(A_GPIO_CMD, 32'h0003_0000);
        bus_read(A_STATUS, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL stop_in_idle: got %h want 0", rd);
        end

        bus_write(A_TIMEOUT, 32'd0);
        b = hi_cnt[1];
        bus_write(A_GPIO_CMD, 32'h2);
        idle(2);
        bus_read(A_STATUS, rd);
        n_checks++;
        if (hi_cnt[1] - b !== 0 || rd !== 32'h0002_0000) begin
            n_fail++;
            $display("FAIL zero_timeout: got high=%0d status=%h want 0 and 00020000", hi_cnt[1] - b, rd);
        end
        bus_write(A_STATUS, 32'hFFFF_0000);

        t = int'($urandom_range(3, 20));
        bus_write(A_TIMEOUT, 32'(t));
        bus_write(A_GPIO_CMD, 32'h1);
        idle(t - 1);
        bus_write(A_STATUS, 32'h0001_0000);
        bus_read(A_STATUS, rd);
        n_checks++;
        if (rd !== 32'h0001_0000) begin
            n_fail++;
            $display("FAIL w1c_in_expiry_cycle T=%0d: got %h want 00010000", t, rd);
        end
        bus_write(A_STATUS, 32'h0001_0000);
        bus_read(A_STATUS, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL w1c_after_expiry: got %h want 0", rd);
        end
    endtask

    task automatic test_blink();
        logic [7:0] v, mk, exp_l;
        int h, ph;
        for (int it = 0; it < 3; it++) begin
            v  = (it == 0) ? 8'hFF : 8'($urandom);
            mk = (it == 0) ? 8'h0F : 8'($urandom);
            h  = (it == 0) ? 4 : int'($urandom_range(1, 6));
            bus_write(A_LED_VAL, 32'(v));
            bus_write(A_LED_BLINK, 32'(mk));
            bus_write(A_BLINK_HALF, 32'(h));
            for (int k = 0; k < 4 * h + 4; k++) begin
                @(negedge clk);
                if (k >= 1) begin
                    ph    = ((k - 1) / h) % 2;
                    exp_l = v & (~mk | {8{ph[0]}});
                    n_checks++;
                    if (leds !== exp_l) begin
                        n_fail++;
                        $display("FAIL blink_leds H=%0d k=%0d: got %h want %h", h, k, leds, exp_l);
                    end
                end
            end
            @(posedge clk);
            #1;
            bus_write(A_BLINK_HALF, 32'd0);
            idle(2);
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                n_checks++;
                if (leds !== (v & ~mk)) begin
                    n_fail++;
                    $display("FAIL blink_half_zero k=%0d: got %h want %h", k, leds, v & ~mk);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reads_back_to_back();
        logic [31:0] rd, d1, d2, d3, d4, tv;
        bus_write(A_GPIO_CMD, 32'hFFFF_0000);
        for (int a = 3; a < 8; a++) begin
            if (a == 4 || a == 5) continue;
            bus_read(3'(a), rd);
            n_checks++;
            if (rd !== 32'h0) begin
                n_fail++;
                $display("FAIL unmapped_or_wo_read addr%0d: got %h want 0", a, rd);
            end
        end
        bus_write(A_LED_VAL, 32'hFFFF_FFFF);
        bus_write(3'd6, 32'hDEAD_BEEF);
        bus_write(3'd7, 32'h1234_5678);
        bus_read(A_LED_VAL, rd);
        n_checks++;
        if (rd !== 32'h0000_00FF) begin
            n_fail++;
            $display("FAIL led_val_truncate: got %h want 000000ff", rd);
        end
        tv = $urandom;
        bus_write(A_TIMEOUT, tv);
        bus_read(A_TIMEOUT, rd);
        n_checks++;
        if (rd !== tv) begin
            n_fail++;
            $display("FAIL timeout_readback: got %h want %h", rd, tv);
        end

        bus_write(A_TIMEOUT, 32'd300);
        bus_write(A_GPIO_CMD, 32'h2);
        avs_address = A_STATUS;
        avs_read    = 1'b1;
        @(posedge clk);
        #1;
        d1 = avs_readdata;
        @(posedge clk);
        #1;
        d2 = avs_readdata;
        avs_address = A_TIMEOUT;
        @(posedge clk);
        #1;
        d3 = avs_readdata;
        avs_read = 1'b0;
        avs_address = A_STATUS;
        @(posedge clk);
        #1;
        d4 = avs_readdata;
        n_checks++;
        if (d1 !== 32'h2 || d2 !== 32'h2) begin
            n_fail++;
            $display("FAIL b2b_status: got %h %h want 00000002 00000002", d1, d2);
        end
        n_checks++;
        if (d3 !== 32'd300) begin
            n_fail++;
            $display("FAIL b2b_timeout: got %h want %h", d3, 32'd300);
        end
        n_checks++;
        if (d4 !== 32'd300) begin
            n_fail++;
            $display("FAIL readdata_hold: got %h want %h", d4, 32'd300);
        end
        bus_write(A_GPIO_CMD, 32'h0002_0000);
        idle(2);
        bus_read(A_STATUS, rd);
        n_checks++;
        if (rd !== 32'h0 || gpio !== '0) begin
            n_fail++;
            $display("FAIL final_stop: got status=%h gpio=%b want 0", rd, gpio);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_timeout();
        test_retrigger_stop();
        test_edge_cases();
        test_blink();
        test_reads_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
